// File: rtl/wb_stage.sv
// Writeback stage: retires execute-2 results into the 16x16 register file and
// owns PC redirect/squash, the r0 print side-channel, sticky halt and retire count.
module wb_stage #(
  parameter int FLUSH_DEPTH = 3,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             x2_valid,
  input  logic [15:0]      x2_pc,
  input  logic [15:0]      x2_ins,
  input  logic [15:0]      x2_result,
  input  logic [3:0]       rd_addr_a,
  input  logic [3:0]       rd_addr_b,
  output logic [15:0]      rd_data_a,
  output logic [15:0]      rd_data_b,
  output logic             wb_redirect,
  output logic [15:0]      wb_target,
  output logic             print_valid,
  output logic [7:0]       print_char,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  localparam int SQ_W = (FLUSH_DEPTH < 1) ? 1 : $clog2(FLUSH_DEPTH + 1);

  logic [15:0]      regs_r [0:15];
  logic [SQ_W-1:0]  squash_cnt_r;
  logic             halted_r;
  logic             redirect_r;
  logic [15:0]      target_r;
  logic             print_valid_r;
  logic [7:0]       print_char_r;
  logic [CNT_W-1:0] retired_r;

  logic [3:0]  opcode_s;
  logic [3:0]  sub_s;
  logic [3:0]  rt_s;
  logic        squash_active_s;
  logic        eff_s;
  logic        writes_s;
  logic        illegal_s;
  logic        is_jump_s;
  logic [15:0] pc_plus2_s;
  logic        jump_taken_s;
  logic        wr_en_s;
  logic        reg_wr_s;
  logic        print_s;
  logic        retire_s;
  logic        squash_dec_s;

  // Instruction decode and retire qualification.
  always_comb begin
    opcode_s        = x2_ins[15:12];
    sub_s           = x2_ins[7:4];
    rt_s            = x2_ins[3:0];
    squash_active_s = (squash_cnt_r != {SQ_W{1'b0}});
    // An instruction presented while rst is high is discarded outright.
    eff_s           = x2_valid & ~squash_active_s & ~halted_r & ~rst;

    case (opcode_s)
      4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd14: writes_s = 1'b1;
      4'd7:                                      writes_s = (sub_s == 4'd0);
      default:                                   writes_s = 1'b0;
    endcase

    case (opcode_s)
      4'd8, 4'd9, 4'd10, 4'd11, 4'd15: illegal_s = 1'b1;
      default:                         illegal_s = 1'b0;
    endcase

    is_jump_s    = (opcode_s == 4'd6) && (sub_s[3:2] == 2'b00);
    pc_plus2_s   = x2_pc + 16'd2;
    jump_taken_s = eff_s & is_jump_s & (x2_result != pc_plus2_s);
    wr_en_s      = eff_s & writes_s;
    reg_wr_s     = wr_en_s & (rt_s != 4'd0);
    print_s      = wr_en_s & (rt_s == 4'd0);
    retire_s     = eff_s & ~illegal_s;
    squash_dec_s = x2_valid & squash_active_s & ~halted_r;
  end

  // Read port A with write-through bypass; r0 is hardwired to zero.
  always_comb begin
    if (rd_addr_a == 4'd0) begin
      rd_data_a = 16'h0000;
    end else if (reg_wr_s && (rt_s == rd_addr_a)) begin
      rd_data_a = x2_result;
    end else begin
      rd_data_a = regs_r[rd_addr_a];
    end
  end

  // Read port B with write-through bypass; r0 is hardwired to zero.
  always_comb begin
    if (rd_addr_b == 4'd0) begin
      rd_data_b = 16'h0000;
    end else if (reg_wr_s && (rt_s == rd_addr_b)) begin
      rd_data_b = x2_result;
    end else begin
      rd_data_b = regs_r[rd_addr_b];
    end
  end

  // Architectural register file storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        regs_r[i] <= 16'h0000;
      end
    end else if (reg_wr_s) begin
      regs_r[rt_s] <= x2_result;
    end else begin
      regs_r[rt_s] <= regs_r[rt_s];
    end
  end

  // Squash counter, halt, retire count and the registered side outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      squash_cnt_r  <= {SQ_W{1'b0}};
      halted_r      <= 1'b0;
      redirect_r    <= 1'b0;
      target_r      <= 16'h0000;
      print_valid_r <= 1'b0;
      print_char_r  <= 8'h00;
      retired_r     <= {CNT_W{1'b0}};
    end else begin
      // A taken jump can only come from an effective instruction, so it never
      // overlaps with a decrement of an already-active squash window.
      if (jump_taken_s) begin
        squash_cnt_r <= SQ_W'(FLUSH_DEPTH);
      end else if (squash_dec_s) begin
        squash_cnt_r <= squash_cnt_r - {{(SQ_W-1){1'b0}}, 1'b1};
      end else begin
        squash_cnt_r <= squash_cnt_r;
      end

      if (eff_s && illegal_s) begin
        halted_r <= 1'b1;
      end else begin
        halted_r <= halted_r;
      end

      redirect_r <= jump_taken_s;
      if (jump_taken_s) begin
        target_r <= x2_result;
      end else begin
        target_r <= target_r;
      end

      print_valid_r <= print_s;
      if (print_s) begin
        print_char_r <= x2_result[7:0];
      end else begin
        print_char_r <= print_char_r;
      end

      if (retire_s) begin
        retired_r <= retired_r + CNT_W'(1);
      end else begin
        retired_r <= retired_r;
      end
    end
  end

  assign wb_redirect = redirect_r;
  assign wb_target   = target_r;
  assign print_valid = print_valid_r;
  assign print_char  = print_char_r;
  assign halted      = halted_r;
  assign retired     = retired_r;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios plus a randomized run
// checked against an instruction-level reference model.
module tb_wb_stage;
  localparam int FD = 3;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          x2_valid;
  logic [15:0]   x2_pc, x2_ins, x2_result;
  logic [3:0]    rd_addr_a, rd_addr_b;
  logic [15:0]   rd_data_a, rd_data_b;
  logic          wb_redirect;
  logic [15:0]   wb_target;
  logic          print_valid;
  logic [7:0]    print_char;
  logic          halted;
  logic [CW-1:0] retired;

  wb_stage #(.FLUSH_DEPTH(FD), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .x2_valid(x2_valid), .x2_pc(x2_pc), .x2_ins(x2_ins),
    .x2_result(x2_result), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b), .wb_redirect(wb_redirect),
    .wb_target(wb_target), .print_valid(print_valid), .print_char(print_char),
    .halted(halted), .retired(retired)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state (instruction-level view of the architecture).
  logic [15:0]   m_regs [16];
  int            m_squash;
  bit            m_halted;
  logic [CW-1:0] m_retired;
  bit            m_redirect;
  logic [15:0]   m_target;
  bit            m_pv;
  logic [7:0]    m_pchar;

  function automatic bit ins_writes(logic [15:0] ins);
    int op = int'(ins[15:12]);
    return (op <= 5) || (op == 14) || (op == 7 && ins[7:4] == 4'd0);
  endfunction

  function automatic bit ins_illegal(logic [15:0] ins);
    int op = int'(ins[15:12]);
    return (op >= 8 && op <= 11) || (op == 15);
  endfunction

  function automatic bit model_eff();
    return x2_valid && !rst && !m_halted && (m_squash == 0);
  endfunction

  function automatic logic [15:0] exp_rd(logic [3:0] a);
    if (a == 4'd0) return 16'h0000;
    if (model_eff() && ins_writes(x2_ins) && x2_ins[3:0] == a) return x2_result;
    return m_regs[a];
  endfunction

  task automatic model_step();
    m_redirect = 1'b0;
    m_pv       = 1'b0;
    if (rst) begin
      for (int i = 0; i < 16; i++) m_regs[i] = 16'h0000;
      m_squash = 0; m_halted = 1'b0; m_retired = '0;
      m_target = 16'h0000; m_pchar = 8'h00;
    end else if (x2_valid && !m_halted) begin
      if (m_squash > 0) begin
        m_squash--;
      end else if (ins_illegal(x2_ins)) begin
        m_halted = 1'b1;
      end else begin
        m_retired++;
        if (ins_writes(x2_ins)) begin
          if (x2_ins[3:0] == 4'd0) begin
            m_pv = 1'b1; m_pchar = x2_result[7:0];
          end else begin
            m_regs[x2_ins[3:0]] = x2_result;
          end
        end
        if (x2_ins[15:12] == 4'd6 && x2_ins[7:4] <= 4'd3 && x2_result != x2_pc + 16'd2) begin
          m_redirect = 1'b1; m_target = x2_result; m_squash = FD;
        end
      end
    end
  endtask

  task automatic set_in(input logic v, input logic [15:0] pc, input logic [15:0] ins,
                        input logic [15:0] res);
    x2_valid = v; x2_pc = pc; x2_ins = ins; x2_result = res;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; rd_addr_a = 4'd0; rd_addr_b = 4'd0;
    set_in(1'b1, 16'h0000, 16'h0123, 16'h0099);
    tick();
    tick();
    rst = 1'b0;
    set_in(1'b0, 16'h0000, 16'h0000, 16'h0000);
    tick();
    total++; if (retired !== 32'd0) begin bad++; $display("FAIL reset_retired got=%0d exp=0", retired); end
    total++; if (halted !== 1'b0) begin bad++; $display("FAIL reset_halted got=%b exp=0", halted); end
    total++; if (wb_redirect !== 1'b0) begin bad++; $display("FAIL reset_redirect got=%b exp=0", wb_redirect); end
    total++; if (print_valid !== 1'b0) begin bad++; $display("FAIL reset_print got=%b exp=0", print_valid); end
    for (int a = 0; a < 16; a++) begin
      rd_addr_a = 4'(a); rd_addr_b = 4'(15 - a); #1;
      total++; if (rd_data_a !== 16'h0000) begin bad++; $display("FAIL reset_reg_a r%0d got=%h exp=0000", a, rd_data_a); end
      total++; if (rd_data_b !== 16'h0000) begin bad++; $display("FAIL reset_reg_b r%0d got=%h exp=0000", 15 - a, rd_data_b); end
    end
  endtask

  task automatic test_add_bypass();
    set_in(1'b1, 16'h0000, 16'h0123, 16'h0042); rd_addr_a = 4'd3; #2;
    total++; if (rd_data_a !== 16'h0042) begin bad++; $display("FAIL add_bypass got=%h exp=0042", rd_data_a); end
    tick();
    set_in(1'b0, 16'h0000, 16'h0000, 16'h0000); #1;
    total++; if (rd_data_a !== 16'h0042) begin bad++; $display("FAIL add_stored got=%h exp=0042", rd_data_a); end
    total++; if (retired !== 32'd1) begin bad++; $display("FAIL add_retired got=%0d exp=1", retired); end
  endtask

  task automatic test_print();
    logic [CW-1:0] base = retired;
    set_in(1'b1, 16'h0000, 16'h4410, 16'h0041); rd_addr_a = 4'd0; #2;
    total++; if (rd_data_a !== 16'h0000) begin bad++; $display("FAIL print_r0_read got=%h exp=0000", rd_data_a); end
    tick();
    total++; if (print_valid !== 1'b1) begin bad++; $display("FAIL print_valid got=%b exp=1", print_valid); end
    total++; if (print_char !== 8'h41) begin bad++; $display("FAIL print_char got=%h exp=41", print_char); end
    set_in(1'b0, 16'h0000, 16'h0000, 16'h0000);
    tick();
    total++; if (print_valid !== 1'b0) begin bad++; $display("FAIL print_pulse got=%b exp=0", print_valid); end
    total++; if (retired !== base + 1) begin bad++; $display("FAIL print_retired got=%0d exp=%0d", retired, base + 1); end
  endtask

  task automatic test_jump_squash();
    logic [CW-1:0] base = retired;
    rd_addr_b = 4'd5;
    set_in(1'b1, 16'h0010, 16'h6102, 16'h0080);
    tick();
    total++; if (wb_redirect !== 1'b1) begin bad++; $display("FAIL jump_redirect got=%b exp=1", wb_redirect); end
    total++; if (wb_target !== 16'h0080) begin bad++; $display("FAIL jump_target got=%h exp=0080", wb_target); end
    set_in(1'b1, 16'h0000, 16'h0125, 16'h5555); #1;
    total++; if (rd_data_b !== 16'h0000) begin bad++; $display("FAIL squash_no_bypass got=%h exp=0000", rd_data_b); end
    tick();
    total++; if (wb_redirect !== 1'b0) begin bad++; $display("FAIL jump_one_cycle got=%b exp=0", wb_redirect); end
    set_in(1'b0, 16'h0000, 16'h0125, 16'h9999); tick();
    set_in(1'b1, 16'h0000, 16'h0125, 16'h6666); tick();
    set_in(1'b1, 16'h0000, 16'h0125, 16'h7777); tick();
    set_in(1'b0, 16'h0000, 16'h0000, 16'h0000); #1;
    total++; if (rd_data_b !== 16'h0000) begin bad++; $display("FAIL squash_r5 got=%h exp=0000", rd_data_b); end
    total++; if (retired !== base + 1) begin bad++; $display("FAIL squash_retired got=%0d exp=%0d", retired, base + 1); end
    set_in(1'b1, 16'h0000, 16'h0125, 16'h1234); tick();
    set_in(1'b0, 16'h0000, 16'h0000, 16'h0000); #1;
    total++; if (rd_data_b !== 16'h1234) begin bad++; $display("FAIL fourth_retires got=%h exp=1234", rd_data_b); end
    total++; if (retired !== base + 2) begin bad++; $display("FAIL fourth_retired got=%0d exp=%0d", retired, base + 2); end
  endtask

  task automatic test_not_taken();
    logic [CW-1:0] base = retired;
    set_in(1'b1, 16'hFFFE, 16'h6000, 16'h0000); tick();
    total++; if (wb_redirect !== 1'b0) begin bad++; $display("FAIL nt_wrap got=%b exp=0", wb_redirect); end
    set_in(1'b1, 16'h0020, 16'h6300, 16'h0022); tick();
    total++; if (wb_redirect !== 1'b0) begin bad++; $display("FAIL nt_plain got=%b exp=0", wb_redirect); end
    set_in(1'b1, 16'h0000, 16'h6040, 16'h0100); tick();
    total++; if (wb_redirect !== 1'b0) begin bad++; $display("FAIL sub4_jump got=%b exp=0", wb_redirect); end
    set_in(1'b1, 16'h0000, 16'h0126, 16'hABCD); tick();
    set_in(1'b0, 16'h0000, 16'h0000, 16'h0000); rd_addr_a = 4'd6; #1;
    total++; if (rd_data_a !== 16'hABCD) begin bad++; $display("FAIL nt_no_squash got=%h exp=abcd", rd_data_a); end
    total++; if (retired !== base + 4) begin bad++; $display("FAIL nt_retired got=%0d exp=%0d", retired, base + 4); end
  endtask

  task automatic test_store_vector();
    logic [CW-1:0] base = retired;
    set_in(1'b1, 16'h0000, 16'h7010, 16'h0055); tick();
    total++; if (print_valid !== 1'b0) begin bad++; $display("FAIL store_print got=%b exp=0", print_valid); end
    set_in(1'b1, 16'h0000, 16'hC000, 16'h0066); tick();
    total++; if (print_valid !== 1'b0) begin bad++; $display("FAIL vector_print got=%b exp=0", print_valid); end
    set_in(1'b1, 16'h0000, 16'h7013, 16'h0077); rd_addr_a = 4'd3; #1;
    total++; if (rd_data_a !== 16'h0042) begin bad++; $display("FAIL store_no_bypass got=%h exp=0042", rd_data_a); end
    tick();
    set_in(1'b0, 16'h0000, 16'h0000, 16'h0000); #1;
    total++; if (rd_data_a !== 16'h0042) begin bad++; $display("FAIL store_no_write got=%h exp=0042", rd_data_a); end
    total++; if (retired !== base + 3) begin bad++; $display("FAIL store_retired got=%0d exp=%0d", retired, base + 3); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      logic [3:0]  op = 4'($urandom_range(0, 15));
      logic [15:0] pc = 16'($urandom);
      logic [15:0] ins;
      logic [15:0] res = 16'($urandom);
      if ((op >= 4'd8 && op <= 4'd11) || op == 4'd15) op = 4'($urandom_range(0, 7));
      ins = {op, 12'($urandom)};
      if (op == 4'd6 && $urandom_range(0, 1) == 0) res = pc + 16'd2;
      set_in($urandom_range(0, 3) != 0, pc, ins, res);
      rd_addr_a = 4'($urandom); rd_addr_b = ins[3:0]; #2;
      total++; if (rd_data_a !== exp_rd(rd_addr_a)) begin bad++; $display("FAIL rnd_rd_a n=%0d got=%h exp=%h", n, rd_data_a, exp_rd(rd_addr_a)); end
      total++; if (rd_data_b !== exp_rd(rd_addr_b)) begin bad++; $display("FAIL rnd_rd_b n=%0d got=%h exp=%h", n, rd_data_b, exp_rd(rd_addr_b)); end
      tick();
      total++; if (wb_redirect !== m_redirect) begin bad++; $display("FAIL rnd_redirect n=%0d got=%b exp=%b", n, wb_redirect, m_redirect); end
      if (m_redirect) begin
        total++; if (wb_target !== m_target) begin bad++; $display("FAIL rnd_target n=%0d got=%h exp=%h", n, wb_target, m_target); end
      end
      total++; if (print_valid !== m_pv) begin bad++; $display("FAIL rnd_print n=%0d got=%b exp=%b", n, print_valid, m_pv); end
      if (m_pv) begin
        total++; if (print_char !== m_pchar) begin bad++; $display("FAIL rnd_pchar n=%0d got=%h exp=%h", n, print_char, m_pchar); end
      end
      total++; if (retired !== m_retired) begin bad++; $display("FAIL rnd_retired n=%0d got=%0d exp=%0d", n, retired, m_retired); end
      total++; if (halted !== m_halted) begin bad++; $display("FAIL rnd_halted n=%0d got=%b exp=%b", n, halted, m_halted); end
    end
  endtask

  task automatic test_reset_during_squash();
    rst = 1'b1; set_in(1'b0, 16'h0000, 16'h0000, 16'h0000); tick(); rst = 1'b0;
    set_in(1'b1, 16'h0040, 16'h6000, 16'h0200); tick();
    total++; if (wb_redirect !== 1'b1) begin bad++; $display("FAIL rsq_redirect got=%b exp=1", wb_redirect); end
    set_in(1'b1, 16'h0000, 16'h0127, 16'h1111); tick();
    rst = 1'b1; set_in(1'b1, 16'h0000, 16'h0127, 16'hEEEE); tick(); rst = 1'b0;
    total++; if (retired !== 32'd0) begin bad++; $display("FAIL rsq_cleared got=%0d exp=0", retired); end
    set_in(1'b1, 16'h0000, 16'h0127, 16'h0777); tick();
    set_in(1'b0, 16'h0000, 16'h0000, 16'h0000); rd_addr_a = 4'd7; #1;
    total++; if (rd_data_a !== 16'h0777) begin bad++; $display("FAIL rsq_first_retires got=%h exp=0777", rd_data_a); end
    total++; if (retired !== 32'd1) begin bad++; $display("FAIL rsq_retired got=%0d exp=1", retired); end
  endtask

  task automatic test_halt();
    set_in(1'b1, 16'h0000, 16'h8000, 16'h0000); tick();
    total++; if (halted !== 1'b1) begin bad++; $display("FAIL halt_set got=%b exp=1", halted); end
    total++; if (retired !== 32'd1) begin bad++; $display("FAIL halt_not_counted got=%0d exp=1", retired); end
    set_in(1'b1, 16'h0000, 16'h0122, 16'h7777); rd_addr_a = 4'd2; #2;
    total++; if (rd_data_a !== 16'h0000) begin bad++; $display("FAIL halt_no_bypass got=%h exp=0000", rd_data_a); end
    tick();
    set_in(1'b1, 16'h0010, 16'h6000, 16'h0300); tick();
    total++; if (wb_redirect !== 1'b0) begin bad++; $display("FAIL halt_no_redirect got=%b exp=0", wb_redirect); end
    set_in(1'b1, 16'h0000, 16'h4410, 16'h0043); tick();
    total++; if (print_valid !== 1'b0) begin bad++; $display("FAIL halt_no_print got=%b exp=0", print_valid); end
    set_in(1'b0, 16'h0000, 16'h0000, 16'h0000); #1;
    total++; if (rd_data_a !== 16'h0000) begin bad++; $display("FAIL halt_no_write got=%h exp=0000", rd_data_a); end
    total++; if (retired !== 32'd1) begin bad++; $display("FAIL halt_frozen got=%0d exp=1", retired); end
    total++; if (halted !== 1'b1) begin bad++; $display("FAIL halt_sticky got=%b exp=1", halted); end
    rst = 1'b1; tick(); rst = 1'b0; rd_addr_a = 4'd7; #1;
    total++; if (halted !== 1'b0) begin bad++; $display("FAIL halt_rst_clear got=%b exp=0", halted); end
    total++; if (rd_data_a !== 16'h0000) begin bad++; $display("FAIL halt_rst_regs got=%h exp=0000", rd_data_a); end
  endtask

  initial begin
    test_reset();
    test_add_bypass();
    test_print();
    test_jump_squash();
    test_not_taken();
    test_store_vector();
    test_random();
    test_reset_during_squash();
    test_halt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback stage directly downstream of the two-cycle execute unit.
- Consumes the execute-2 result, instruction and PC, and retires each instruction.
- Owns the architectural register file (16 x 16-bit) and serves decode's two read ports.
- Raises the PC redirect for taken jumps and squashes wrong-path instructions behind it.
- Drives the print side-channel and the sticky halt.

Parameters:
- FLUSH_DEPTH, 3, number of younger valid instructions squashed after a redirect.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- x2_valid  input  1  x2_ins/x2_pc/x2_result carry a real instruction this cycle
- x2_pc  input  16  PC of the instruction in execute-2
- x2_ins  input  16  instruction in execute-2
- x2_result  input  16  execute-2 result (arith value, load data, next PC for jumps, store data)
- rd_addr_a  input  4  decode read port A index
- rd_addr_b  input  4  decode read port B index
- rd_data_a  output  16  register value for rd_addr_a
- rd_data_b  output  16  register value for rd_addr_b
- wb_redirect  output  1  one-cycle pulse: fetch must restart at wb_target
- wb_target  output  16  redirect PC
- print_valid  output  1  one-cycle pulse: print_char is valid
- print_char  output  8  character written via r0
- halted  output  1  sticky halt
- retired  output  CNT_W  count of retired (non-squashed) instructions

Behaviour:
- Field decode: opcode = ins[15:12], ra = ins[11:8], rb/subcode = ins[7:4], rt = ins[3:0].
- Opcodes: 0 add, 1 sub, 2 mul, 3 div, 4 movl, 5 movh, 6 jump (subcode 0-3), 7 scalar ld (sub 0)/st (sub 1), 12/13 vector mem, 14 dot. Opcodes 8-11 and 15 are illegal.
- Effective valid: eff = x2_valid & ~squash_active & ~halted.
- Register write when eff and the instruction is one of: opcodes 0-5, 14, or opcode 7 with subcode 0.
  - Write data = x2_result, written on the rising edge into rt.
  - Stores, jumps and vector mem (12/13) write nothing.
- r0: reads always return 0 and r0 is never written.
  - A qualifying write with rt=0 instead registers print_valid=1 and print_char=x2_result[7:0] for exactly one cycle.
- Read ports are combinational with write-through bypass.
  - If a write is qualifying this cycle, rt≠0 and rt==rd_addr, return x2_result; otherwise return the stored value.
- Jumps (opcode 6, eff): taken iff x2_result != x2_pc+2 (16-bit wrap).
  - Taken: next cycle wb_redirect=1 and wb_target=x2_result, held one cycle.
  - Taken: squash counter loads FLUSH_DEPTH.
  - Not taken: no redirect.
- Squash counter: squash_active = (cnt != 0).
  - Each cycle with x2_valid=1 while active decrements cnt.
  - Bubbles (x2_valid=0) do not decrement.
  - Squashed instructions have no side effects and are not counted.
- Illegal opcode with eff: halted←1 next cycle; that instruction writes nothing and is not counted.
  - After halt every input is ignored, and redirect and print stay 0, until rst.
- retired increments by 1 for every eff instruction except illegal ones.
  - Taken jumps count; squashed ones do not. Wraps modulo 2^CNT_W.
- A subcode 4-15 jump is not taken (no redirect), counts as retired, writes nothing.
- Reset (sync, rst=1 at edge; takes effect mid-operation): all 16 registers←0, cnt←0, halted←0, retired←0, wb_redirect←0, wb_target←0, print_valid←0, print_char←0.
  - An instruction presented during rst is discarded.
- Latency: register write visible through the bypass in the same cycle and from storage the cycle after. Redirect, print and halt outputs are valid one cycle after the retiring edge.

Test Plan:
- Reset, then add ins 16'h0123 with result 16'h0042, valid → rd_addr_a=3 reads 16'h0042 in the same cycle (bypass) and next cycle; retired=1.
- movl ins 16'h4410 to r0 with result 16'h0041 → print_valid pulses once with print_char=8'h41; rd_addr_a=0 still reads 0.
- Jump x2_pc=16'h0010, ins 16'h6102, result 16'h0080 → wb_redirect=1, wb_target=16'h0080 for one cycle.
  - Next three valid instructions (an add to r5 interleaved with one bubble) are squashed: r5 unchanged, retired grows by 1 only.
  - The fourth valid instruction retires.
- Jump with result == x2_pc+2, including x2_pc=16'hFFFE with result 16'h0000 → no redirect, no squash, retired+1.
- Illegal ins 16'h8000 valid → halted=1 next cycle; a following add to r2 does not write and retired is frozen.
  - rst then clears halted and all registers to 0.
- Store ins 16'h7010 and vector ins 16'hC000 → no register write, no print; retired+2.
  - rst asserted while a squash is active → cnt cleared, first instruction after rst retires.
